// File: rtl/bpm_pkg.sv
// Shared definitions for the BPM click generator and the BPM detector:
// tempo clamp defaults, constant widths and the click state encoding.
package bpm_pkg;

  localparam int unsigned MIN_BPM_DEFAULT = 40;
  localparam int unsigned MAX_BPM_DEFAULT = 200;
  localparam int unsigned CONST_W         = 32;
  localparam int unsigned DIV_W           = 16;

  typedef enum logic {
    IDLE,
    CLICK
  } click_state_t;

  // Clock cycles per minute; widened first so 60*50 MHz does not overflow.
  function automatic logic [CONST_W-1:0] ticks_per_minute(input longint unsigned clk_hz);
    return CONST_W'(clk_hz * 64'd60);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle plus a final
// completion cycle, so busy stays high for DIVIDEND_W+1 cycles.
module seq_divider
  import bpm_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = CONST_W,
  parameter int unsigned DIVISOR_W  = DIV_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  den_q, den_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W:0]    trial;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    step_d = step_q;
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    trial  = {rem_q, quo_q[DIVIDEND_W-1]};
    if (!busy_q) begin
      if (start_i) begin
        busy_d = 1'b1;
        step_d = '0;
        rem_d  = '0;
        quo_d  = dividend_i;
        den_d  = divisor_i;
      end
    end else if (step_q == CNT_W'(DIVIDEND_W)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else begin
      // Dividend bits shift out of quo_q as quotient bits shift in.
      step_d = step_q + 1'b1;
      if (trial >= {1'b0, den_q}) begin
        rem_d = DIVISOR_W'(trial - {1'b0, den_q});
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIVISOR_W-1:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/bpm_click_generator.sv
// Metronome: converts a BPM setting into a beat strobe and emits a decaying
// square-tone click burst per beat over a valid/ready sample stream.
module bpm_click_generator
  import bpm_pkg::*;
#(
  parameter int unsigned            SAMPLE_WIDTH     = 16,
  parameter int unsigned            CLOCK_FREQ       = 50_000_000,
  parameter int unsigned            BPM_WIDTH        = 16,
  parameter int unsigned            MIN_BPM          = MIN_BPM_DEFAULT,
  parameter int unsigned            MAX_BPM          = MAX_BPM_DEFAULT,
  parameter int unsigned            CLICK_SAMPLES    = 64,
  parameter int unsigned            TONE_HALF_PERIOD = 4,
  parameter logic [SAMPLE_WIDTH-1:0] CLICK_AMPLITUDE = 16'h4000,
  parameter int unsigned            DECAY_SHIFT      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BPM_WIDTH-1:0]    bpm_in,
  input  logic                    bpm_load,
  input  logic                    enable,
  input  logic                    sample_tick,
  output logic [SAMPLE_WIDTH-1:0] click_data,
  output logic                    click_valid,
  input  logic                    click_ready,
  output logic                    beat_pulse,
  output logic                    busy,
  output logic [31:0]             interval_out,
  output logic                    overrun
);

  localparam logic [CONST_W-1:0] TICKS = ticks_per_minute(CLOCK_FREQ);
  localparam int unsigned        IDX_W = $clog2(CLICK_SAMPLES + 1);

  logic [31:0]        bpm_ext, bpm_clamped;
  logic               div_start, div_busy, div_done;
  logic [CONST_W-1:0] div_quo;

  always_comb begin
    bpm_ext     = 32'(bpm_in);
    bpm_clamped = bpm_ext;
    if (bpm_ext < MIN_BPM) bpm_clamped = MIN_BPM;
    if (bpm_ext > MAX_BPM) bpm_clamped = MAX_BPM;
  end

  assign div_start = bpm_load && !div_busy;
  assign busy      = div_busy;

  seq_divider #(
    .DIVIDEND_W (CONST_W),
    .DIVISOR_W  (DIV_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (TICKS),
    .divisor_i  (DIV_W'(bpm_clamped)),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  logic [31:0] active_q, active_d, pend_q, pend_d, cnt_q, cnt_d;
  logic        pend_vld_q, pend_vld_d, run_q, beat_q, beat_d;
  logic        run, start, wrap, apply_ok;

  always_comb begin
    run        = enable && (active_q != '0);
    start      = run && !run_q;
    wrap       = run && run_q && (cnt_q == active_q - 32'd1);
    beat_d     = start || wrap;
    cnt_d      = (!run || start || wrap) ? '0 : cnt_q + 32'd1;
    // The beat cycle itself is still a boundary: the new period only starts
    // comparing against active_q from here, so a quotient landing now applies.
    apply_ok   = (active_q == '0) || start || wrap || beat_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (apply_ok && (div_done || pend_vld_q)) begin
      active_d   = div_done ? div_quo : pend_q;
      pend_vld_d = 1'b0;
    end else if (div_done) begin
      pend_d     = div_quo;
      pend_vld_d = 1'b1;
    end
  end

  click_state_t            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_inc, half_idx;
  logic [SAMPLE_WIDTH-1:0] amp_q, amp_d, data_q, data_d;
  logic                    valid_q, valid_d, ovr_q, ovr_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    amp_d    = amp_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    idx_inc  = idx_q + 1'b1;
    half_idx = idx_q / IDX_W'(TONE_HALF_PERIOD);
    if (valid_q && click_ready) begin
      valid_d = 1'b0;
      idx_d   = idx_inc;
      if (idx_inc[2:0] == 3'd0) amp_d = amp_q - (amp_q >> DECAY_SHIFT);
      if (idx_inc == IDX_W'(CLICK_SAMPLES)) state_d = IDLE;
    end
    if (sample_tick) begin
      if (valid_q) begin
        ovr_d = 1'b1;
      end else if (state_q == CLICK) begin
        valid_d = 1'b1;
        data_d  = half_idx[0] ? (~amp_q + 1'b1) : amp_q;
      end
    end
    // Restart leaves any presented sample untouched until it is accepted.
    if (beat_q) begin
      state_d = CLICK;
      idx_d   = '0;
      amp_d   = CLICK_AMPLITUDE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      beat_q     <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= '0;
      amp_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      run_q      <= run;
      beat_q     <= beat_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      amp_q      <= amp_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign click_data   = data_q;
  assign click_valid  = valid_q;
  assign beat_pulse   = beat_q;
  assign interval_out = active_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_bpm_click_generator.sv
// Scoreboard bench for bpm_click_generator at CLOCK_FREQ=1000: beat timing,
// tempo loading/clamping, click sample sequence, stalls, overrun and reset.
module tb_bpm_click_generator;

  localparam int CLK_HZ = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bpm_in;
  logic        bpm_load, enable, sample_tick, click_ready;
  logic [15:0] click_data;
  logic        click_valid, beat_pulse, busy, overrun;
  logic [31:0] interval_out;

  bpm_click_generator #(.CLOCK_FREQ(CLK_HZ)) dut (
    .clk          (clk),
    .reset        (reset),
    .bpm_in       (bpm_in),
    .bpm_load     (bpm_load),
    .enable       (enable),
    .sample_tick  (sample_tick),
    .click_data   (click_data),
    .click_valid  (click_valid),
    .click_ready  (click_ready),
    .beat_pulse   (beat_pulse),
    .busy         (busy),
    .interval_out (interval_out),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  logic [15:0] exp_q[$];
  int          beat_q[$];
  bit          tick_en = 1'b0;
  int          tick_per = 5;
  int          ready_mode = 0;

  task automatic check(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int exp_iv(input int bpm);
    int c;
    c = (bpm < 40) ? 40 : (bpm > 200) ? 200 : bpm;
    return (60 * CLK_HZ) / c;
  endfunction

  // Sample k of a burst: square tone of 4-sample half-cycles; magnitude
  // loses an eighth of itself each time 8 more samples have gone out.
  function automatic logic [15:0] ref_sample(input int k);
    int amp;
    amp = 'h4000;
    for (int j = 1; j <= k; j++)
      if (j % 8 == 0) amp = amp - amp / 8;
    return (((k / 4) % 2) == 0) ? 16'(amp) : 16'(-amp);
  endfunction

  initial begin
    sample_tick = 1'b0;
    click_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sample_tick = tick_en && (cyc % tick_per == 0);
      case (ready_mode)
        0:       click_ready = 1'b1;
        1:       click_ready = 1'b0;
        default: click_ready = ($urandom_range(0, 7) != 0);
      endcase
    end
  end

  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [15:0] prev_d = '0;
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (beat_pulse) begin
          check(exp_q.size() == 0, "burst_done_before_beat", exp_q.size(), 0);
          exp_q.delete();
          beat_q.push_back(cyc);
          for (int k = 0; k < 64; k++) exp_q.push_back(ref_sample(k));
        end
        if (prev_v && !prev_r)
          check(click_valid && click_data == prev_d, "stall_hold", {click_valid, click_data}, {1'b1, prev_d});
        if (click_valid && click_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_sample", click_data, 0);
          end else begin
            e = exp_q.pop_front();
            check(click_data == e, "click_sample", click_data, e);
          end
        end
        prev_v = click_valid;
        prev_r = click_ready;
        prev_d = click_data;
      end
    end
  end

  task automatic do_load(input int bpm, output int n);
    bpm_in   = 16'(bpm);
    bpm_load = 1'b1;
    @(negedge clk);
    bpm_load = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic expect_beat(input int exp_c, input string nm);
    int got;
    while (beat_q.size() == 0 && cyc < exp_c + 20) @(negedge clk);
    if (beat_q.size() == 0) begin
      check(1'b0, nm, -1, exp_c);
    end else begin
      got = beat_q.pop_front();
      check(got == exp_c, nm, got, exp_c);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0, "burst_drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(click_data == 16'h0, {tag, "_click_data"}, click_data, 0);
    check(click_valid == 1'b0, {tag, "_click_valid"}, click_valid, 0);
    check(beat_pulse == 1'b0, {tag, "_beat_pulse"}, beat_pulse, 0);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(interval_out == 32'd0, {tag, "_interval"}, interval_out, 0);
    check(overrun == 1'b0, {tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int n, c, b, bpm, iv;
    reset = 1'b1; bpm_in = '0; bpm_load = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick_en = 1'b1;
    @(negedge clk);

    do_load(120, n);
    check(n == 33, "busy_len_120", n, 33);
    @(negedge clk);
    check(interval_out == 32'(exp_iv(120)), "iv_120", interval_out, exp_iv(120));

    enable = 1'b1;
    c = cyc;
    expect_beat(c + 1, "beat_first");
    expect_beat(c + 501, "beat_2");
    expect_beat(c + 1001, "beat_3");
    b = c + 1001;

    wait_until(b + 100);
    bpm_in = 16'd60; bpm_load = 1'b1;
    @(negedge clk);
    bpm_load = 1'b0;
    repeat (5) @(negedge clk);
    check(busy == 1'b1, "busy_mid_divide", busy, 1);
    bpm_in = 16'd250; bpm_load = 1'b1;
    @(negedge clk);
    bpm_load = 1'b0;
    expect_beat(b + 500, "beat_old_period");
    @(negedge clk);
    check(interval_out == 32'd1000, "iv_60_applied", interval_out, 1000);
    expect_beat(b + 1500, "beat_period_1000");
    check(overrun == 1'b0, "overrun_clear", overrun, 0);

    wait_until(b + 1600);
    ready_mode = 1;
    repeat (30) @(negedge clk);
    check(click_valid == 1'b1, "valid_held_low_ready", click_valid, 1);
    check(overrun == 1'b1, "overrun_set", overrun, 1);
    ready_mode = 0;
    expect_beat(b + 2500, "beat_after_stall");
    enable = 1'b0;
    drain();
    check(overrun == 1'b1, "overrun_sticky", overrun, 1);

    do_load(0, n);
    check(n == 33, "busy_len_0", n, 33);
    @(negedge clk);
    check(interval_out == 32'd1000, "pending_held_disabled", interval_out, 1000);
    enable = 1'b1;
    c = cyc;
    expect_beat(c + 1, "beat_start_40");
    check(interval_out == 32'(exp_iv(0)), "iv_clamp_low", interval_out, exp_iv(0));
    wait_until(c + 50);
    do_load(250, n);
    wait_until(c + 400);
    tick_per = 4;
    expect_beat(c + 1501, "beat_period_1500");
    expect_beat(c + 1801, "beat_period_300");
    enable = 1'b0;
    check(interval_out == 32'(exp_iv(250)), "iv_clamp_high", interval_out, exp_iv(250));
    drain();

    ready_mode = 2;
    for (int it = 0; it < 3; it++) begin
      bpm = $urandom_range(0, 130);
      iv  = exp_iv(bpm);
      do_load(bpm, n);
      check(n == 33, "busy_len_rand", n, 33);
      repeat (2) @(negedge clk);
      enable = 1'b1;
      c = cyc;
      expect_beat(c + 1, "beat_rand_start");
      check(interval_out == 32'(iv), "iv_rand", interval_out, iv);
      expect_beat(c + 1 + iv, "beat_rand_period");
      enable = 1'b0;
      drain();
    end

    ready_mode = 0;
    tick_per = 5;
    enable = 1'b1;
    c = cyc;
    expect_beat(c + 1, "beat_pre_reset");
    wait_until(c + 50);
    bpm_in = 16'd120; bpm_load = 1'b1;
    @(negedge clk);
    bpm_load = 1'b0;
    repeat (5) @(negedge clk);
    check(busy == 1'b1, "busy_before_reset", busy, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    beat_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (700) @(negedge clk);
    check(beat_q.size() == 0, "no_beat_after_reset", beat_q.size(), 0);
    check(interval_out == 32'd0, "iv_after_reset", interval_out, 0);
    check(busy == 1'b0, "busy_after_reset", busy, 0);
    enable = 1'b0;
    do_load(120, n);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    c = cyc;
    expect_beat(c + 1, "beat_after_reload");
    enable = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bpm_click_generator.md
# bpm_click_generator

Tempo-driven metronome and click synthesiser, the transmit-side counterpart of the BPM energy detector. It turns a BPM value into a periodic one-cycle beat strobe. On every beat it emits a short decaying square-tone click as a signed audio sample stream over a valid/ready handshake, paced by the codec sample strobe. It sits between the BPM source (detector output or user setting) and the audio output mixer/LED driver.

## Interface
Parameters:
- SAMPLE_WIDTH, 16, click sample width (signed two's complement)
- CLOCK_FREQ, 50_000_000, clk frequency in Hz
- BPM_WIDTH, 16, width of BPM input
- MIN_BPM, 40, lower clamp for BPM
- MAX_BPM, 200, upper clamp for BPM
- CLICK_SAMPLES, 64, samples per click burst
- TONE_HALF_PERIOD, 4, samples per tone half-cycle
- CLICK_AMPLITUDE, 16'h4000, initial click magnitude
- DECAY_SHIFT, 3, amplitude decay shift, applied every 8 samples

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- bpm_in  in  BPM_WIDTH  requested tempo in BPM (unsigned)
- bpm_load  in  1  one-cycle strobe; captures bpm_in
- enable  in  1  beat generation enable
- sample_tick  in  1  one-cycle audio sample-rate strobe
- click_data  out  SAMPLE_WIDTH  click sample
- click_valid  out  1  click_data valid
- click_ready  in  1  downstream accepts sample
- beat_pulse  out  1  one-cycle beat strobe
- busy  out  1  divider computing; bpm_load ignored
- interval_out  out  32  active beat interval in clk cycles
- overrun  out  1  sticky: sample_tick arrived while a sample was still pending

## Operation
- Tempo load: bpm_load while busy=0 clamps bpm_in to [MIN_BPM, MAX_BPM] (0 clamps to MIN_BPM). It then starts an unsigned divide of 60*CLOCK_FREQ (32-bit constant) by the clamped value. The quotient, truncated, becomes the pending interval. bpm_load while busy=1 is ignored.
- Interval apply: if the active interval is 0 (nothing loaded yet), the pending interval becomes active immediately. Otherwise it becomes active at the next beat boundary, so no beat period is ever split between two tempos.
- Beat counter: runs while enable=1 and the active interval is not 0. On enable rising, the counter clears and beat_pulse fires on the next cycle. After that, beat_pulse fires every interval cycles: the counter wraps at interval-1.
- With enable=0, the counter holds at 0 and no beats are produced. A click already in progress finishes.
- Click FSM states:
  - IDLE: on beat_pulse, go to CLICK with idx=0 and amp=CLICK_AMPLITUDE.
  - CLICK: on sample_tick with click_valid=0, present a sample. It is +amp when (idx / TONE_HALF_PERIOD) is even, otherwise -amp.
  - After each valid&&ready transfer: idx increments. When the new idx mod 8 is 0, amp <= amp - (amp >> DECAY_SHIFT).
  - When idx reaches CLICK_SAMPLES, go to IDLE.
- Beat during CLICK restarts the burst (idx=0, amp reset). A pending sample stays unchanged until it is accepted.
- Handshake rules:
  - click_valid stays high and click_data stays stable until click_ready.
  - click_valid is never asserted in IDLE.
  - sample_tick while click_valid=1 is dropped and sets overrun. Only reset clears overrun.
- Simultaneous beat_pulse and divider completion: the completed interval takes effect for the period that starts on that beat.

## Timing
- Reset values: click_data=0, click_valid=0, beat_pulse=0, busy=0, interval_out=0, overrun=0. Counter, FSM (IDLE), amp, idx and pending interval are all cleared. Reset mid-divide aborts the divide.
- Divider: busy rises the cycle after an accepted bpm_load and stays high for exactly 33 cycles. The pending interval is valid on the cycle busy falls. interval_out updates on apply.
- beat_pulse is registered and lasts exactly 1 cycle.
- click_valid rises the cycle after the sample_tick that produces the sample.

## Structure
- Package bpm_pkg holds MIN_BPM/MAX_BPM defaults, the 32-bit constant-width localparam and the click_state_t enum {IDLE, CLICK}.
- Sub-module seq_divider is a restoring 32/16 unsigned divider with start/busy/done and 33-cycle latency. It is reused by the detector for its BPM division.

## Test plan
- CLOCK_FREQ=1000, load 120, enable -> busy high for 33 cycles, interval_out=500. The first beat_pulse comes 1 cycle after enable, then pulses are spaced 500 cycles apart.
- Load 0, then 250 (CLOCK_FREQ=1000) -> intervals 1500 (clamped to 40 BPM) and 300 (clamped to 200 BPM).
- Running at 120 BPM, load 60 mid-period -> the current period stays 500 cycles and the following periods are 1000 cycles. A second bpm_load while busy=1 is ignored.
- Beat with click_ready=1 and sample_tick every 10 cycles -> 64 samples: +0x4000 ×4, then -0x4000 ×4, … The magnitude becomes 0x3800 at sample 8 and 0x3100 at sample 16. The FSM returns to IDLE.
- click_ready held low for 30 cycles across 2 sample_ticks -> click_valid and click_data stay stable and overrun=1 sticks. The burst resumes once ready rises.
- Assert reset mid-click and mid-divide -> all outputs return to reset values within the reset cycle. No beat_pulse follows until a new load and enable.
